periodic_cp_framer: RTL and testbench
=====================================

PERIODIC_CP_FRAMER -- requirements
Module: periodic_cp_framer

Interface
REQ-001 SHALL have parameter SR_FRAME_LEN, default 130, settings address of frame length (FFT size, samples).
REQ-002 SHALL have parameter SR_GAP_LEN, default 131, settings address of gap length (cyclic prefix, samples).
REQ-003 SHALL have parameter SR_OFFSET, default 132, settings address of trigger-to-first-frame offset.
REQ-004 SHALL have parameter SR_NUM_FRAMES, default 133, settings address of frames per trigger.
REQ-005 SHALL have parameter SR_RESERVED, default 134, address accepted and ignored.
REQ-006 SHALL have parameters DEFAULT_FRAME_LEN 64, DEFAULT_GAP_LEN 16, DEFAULT_OFFSET 0, DEFAULT_NUM_FRAMES 1: register reset values.
REQ-007 Ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-008 set_stb in 1, set_addr in 8, set_data in 32: settings bus; lengths use set_data[15:0].
REQ-009 i_tdata in 32 (sc16 I/Q), i_ttrig in 1 (Schmidl-Cox detect, qualified by i_tvalid), i_tlast in 1 (ignored), i_tvalid in 1, i_tready out 1.
REQ-010 o_tdata out 32, o_tlast out 1 (last sample of each frame), o_tvalid out 1, o_tready in 1.
REQ-011 o_busy out 1: high in any state other than IDLE.

Function
REQ-012 Input beat consumed when i_tvalid && i_tready; output beat when o_tvalid && o_tready.
REQ-013 States: IDLE, OFFSET, FRAME, GAP.
REQ-014 IDLE: i_tready=1, o_tvalid=0, beats discarded; consumed beat with i_ttrig=1 and active num_frames!=0 latches frame_len/gap_len/offset/num_frames into shadow registers and leaves IDLE.
REQ-015 Trigger beat is sample index 0; first frame sample is index offset; offset=0 -> go to FRAME with trigger beat emitted as first frame sample, else OFFSET with trigger beat counted as discarded.
REQ-016 OFFSET: i_tready=1, o_tvalid=0; discard offset beats total, then FRAME.
REQ-017 FRAME: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready (combinational pass, zero latency); count frame_len output beats; o_tlast=1 on the frame_len-th.
REQ-018 After last frame beat: if frames emitted == num_frames -> IDLE; else gap_len=0 -> FRAME, else GAP.
REQ-019 GAP: i_tready=1, o_tvalid=0; discard gap_len beats, then FRAME.
REQ-020 Frame spacing in input samples = frame_len + gap_len; no sample dropped or duplicated inside a frame under any backpressure.
REQ-021 i_ttrig outside IDLE ignored (no retrigger, no restart).
REQ-022 Settings writes take effect in live registers immediately but influence framing only at next trigger latch; write to unknown addresses ignored.
REQ-023 frame_len write of 0 stored as 1; gap_len, offset 0 legal; num_frames 0 disables triggering.
REQ-024 Counters 16-bit; maximum values 65535 handled without wrap.
REQ-025 o_tdata, o_tlast SHALL be 0 whenever o_tvalid=0.

Reset
REQ-026 reset SHALL on the next clk edge force IDLE, clear all counters and shadow registers, load live registers with DEFAULT_* values.
REQ-027 During and after reset: o_tvalid=0, o_tlast=0, o_busy=0, i_tready=1; reset mid-frame abandons the frame with no further output beats (partial frame not terminated).

Verification
REQ-028 Settings 64/16/22/12, trigger on input index 100, no backpressure -> 12 frames of 64 beats; frame k first sample = input index 122+80k; o_tlast on indices 185+80k; o_busy falls after index 1065.
REQ-029 Same as REQ-028 with o_tready random 50% and i_tvalid random 70% -> identical output sample sequence and tlast positions.
REQ-030 offset=0, gap=0, num_frames=3, frame_len=4, trigger on index 10 -> outputs indices 10..21, o_tlast on 13, 17, 21.
REQ-031 Second trigger at index 130 during REQ-028 run -> ignored; output unchanged; new trigger at index 2000 after IDLE -> new 12-frame burst starting at 2022.
REQ-032 reset asserted one cycle at frame 2 beat 30 -> o_tvalid=0 next cycle, o_busy=0, registers at defaults (64/16/0/1); later trigger at index T yields exactly one 64-beat frame from T.
REQ-033 num_frames=0 written, trigger applied -> no output, o_busy stays 0; frame_len=0 written then trigger -> single-beat frames with o_tlast every beat.

Source files
------------

// File: rtl/periodic_cp_framer.sv
// periodic_cp_framer: extracts a train of fixed-length frames from a
// sample stream after a trigger. The frames are spaced by a gap, which is
// the cyclic prefix to drop. Frame samples pass through combinationally
// with zero latency. Offset, gap and pre-trigger samples are discarded.
//
// Ports
//   clk, reset                  sole clock, synchronous active-high reset
//   set_stb/set_addr/set_data   settings bus (lengths in set_data[15:0])
//   i_tdata/i_ttrig/i_tlast/
//   i_tvalid/i_tready           input sample stream; i_ttrig marks a detect
//   o_tdata/o_tlast/
//   o_tvalid/o_tready           output frames; o_tlast on last frame sample
//   o_busy                      high while a trigger burst is in progress
module periodic_cp_framer #(
  parameter int unsigned SR_FRAME_LEN       = 130,
  parameter int unsigned SR_GAP_LEN         = 131,
  parameter int unsigned SR_OFFSET          = 132,
  parameter int unsigned SR_NUM_FRAMES      = 133,
  parameter int unsigned SR_RESERVED        = 134,
  parameter int unsigned DEFAULT_FRAME_LEN  = 64,
  parameter int unsigned DEFAULT_GAP_LEN    = 16,
  parameter int unsigned DEFAULT_OFFSET     = 0,
  parameter int unsigned DEFAULT_NUM_FRAMES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_ttrig,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_busy
);

  localparam int unsigned CW = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OFFSET = 2'd1;
  localparam logic [1:0] S_FRAME  = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // A zero frame length is meaningless; it is held as one sample.
  localparam logic [CW-1:0] DEF_FRAME_LEN =
    (DEFAULT_FRAME_LEN == 0) ? CW'(1) : CW'(DEFAULT_FRAME_LEN);
  localparam logic [CW-1:0] DEF_GAP_LEN    = CW'(DEFAULT_GAP_LEN);
  localparam logic [CW-1:0] DEF_OFFSET     = CW'(DEFAULT_OFFSET);
  localparam logic [CW-1:0] DEF_NUM_FRAMES = CW'(DEFAULT_NUM_FRAMES);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] frames_q, frames_d;
  logic [CW-1:0] frame_len_q, frame_len_d;
  logic [CW-1:0] gap_len_q, gap_len_d;
  logic [CW-1:0] offset_q, offset_d;
  logic [CW-1:0] num_frames_q, num_frames_d;
  logic [CW-1:0] sh_frame_len_q, sh_frame_len_d;
  logic [CW-1:0] sh_gap_len_q, sh_gap_len_d;
  logic [CW-1:0] sh_offset_q, sh_offset_d;
  logic [CW-1:0] sh_num_frames_q, sh_num_frames_d;

  logic          trig_ok;
  logic          frame_mode;
  logic          frame_last;
  logic [CW-1:0] eff_frame_len, eff_gap_len, eff_num_frames;
  logic [CW-1:0] cur_cnt, cur_frames, next_frames;

  logic unused_ok;
  assign unused_ok = ^{i_tlast, set_data[31:16]};

  // State and register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      frames_q        <= '0;
      frame_len_q     <= DEF_FRAME_LEN;
      gap_len_q       <= DEF_GAP_LEN;
      offset_q        <= DEF_OFFSET;
      num_frames_q    <= DEF_NUM_FRAMES;
      sh_frame_len_q  <= '0;
      sh_gap_len_q    <= '0;
      sh_offset_q     <= '0;
      sh_num_frames_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      frames_q        <= frames_d;
      frame_len_q     <= frame_len_d;
      gap_len_q       <= gap_len_d;
      offset_q        <= offset_d;
      num_frames_q    <= num_frames_d;
      sh_frame_len_q  <= sh_frame_len_d;
      sh_gap_len_q    <= sh_gap_len_d;
      sh_offset_q     <= sh_offset_d;
      sh_num_frames_q <= sh_num_frames_d;
    end
  end

  // Next state, settings decode and stream steering.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    frames_d        = frames_q;
    frame_len_d     = frame_len_q;
    gap_len_d       = gap_len_q;
    offset_d        = offset_q;
    num_frames_d    = num_frames_q;
    sh_frame_len_d  = sh_frame_len_q;
    sh_gap_len_d    = sh_gap_len_q;
    sh_offset_d     = sh_offset_q;
    sh_num_frames_d = sh_num_frames_q;
    i_tready        = 1'b1;
    o_tvalid        = 1'b0;
    o_tdata         = '0;
    o_tlast         = 1'b0;
    o_busy          = (state_q != S_IDLE);

    if (set_stb) begin
      if (set_addr == 8'(SR_FRAME_LEN))
        frame_len_d = (set_data[15:0] == '0) ? CW'(1) : set_data[15:0];
      else if (set_addr == 8'(SR_GAP_LEN))
        gap_len_d = set_data[15:0];
      else if (set_addr == 8'(SR_OFFSET))
        offset_d = set_data[15:0];
      else if (set_addr == 8'(SR_NUM_FRAMES))
        num_frames_d = set_data[15:0];
    end

    trig_ok = i_tvalid && i_ttrig && (num_frames_q != '0);

    // With zero offset the trigger beat is already frame sample 0, so IDLE
    // behaves as FRAME for that beat, using live settings and zero counts.
    frame_mode = (state_q == S_FRAME) ||
                 ((state_q == S_IDLE) && trig_ok && (offset_q == '0));

    eff_frame_len  = (state_q == S_IDLE) ? frame_len_q  : sh_frame_len_q;
    eff_gap_len    = (state_q == S_IDLE) ? gap_len_q    : sh_gap_len_q;
    eff_num_frames = (state_q == S_IDLE) ? num_frames_q : sh_num_frames_q;
    cur_cnt        = (state_q == S_IDLE) ? '0 : cnt_q;
    cur_frames     = (state_q == S_IDLE) ? '0 : frames_q;
    frame_last     = (cur_cnt == eff_frame_len - CW'(1));
    next_frames    = cur_frames + CW'(1);

    if (frame_mode) begin
      o_tvalid = i_tvalid;
      i_tready = o_tready;
      if (i_tvalid) begin
        o_tdata = i_tdata;
        o_tlast = frame_last;
      end
      if (i_tvalid && o_tready) begin
        if (state_q == S_IDLE) begin
          sh_frame_len_d  = frame_len_q;
          sh_gap_len_d    = gap_len_q;
          sh_offset_d     = offset_q;
          sh_num_frames_d = num_frames_q;
        end
        if (frame_last) begin
          cnt_d    = '0;
          frames_d = next_frames;
          if (next_frames == eff_num_frames) begin
            state_d  = S_IDLE;
            frames_d = '0;
          end else if (eff_gap_len == '0) begin
            state_d = S_FRAME;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          state_d  = S_FRAME;
          cnt_d    = cur_cnt + CW'(1);
          frames_d = cur_frames;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Trigger beat is discarded sample 0 of the offset.
          if (trig_ok) begin
            sh_frame_len_d  = frame_len_q;
            sh_gap_len_d    = gap_len_q;
            sh_offset_d     = offset_q;
            sh_num_frames_d = num_frames_q;
            frames_d        = '0;
            if (offset_q == CW'(1)) begin
              state_d = S_FRAME;
              cnt_d   = '0;
            end else begin
              state_d = S_OFFSET;
              cnt_d   = CW'(1);
            end
          end
        end
        S_OFFSET: begin
          if (i_tvalid) begin
            if (cnt_q == sh_offset_q - CW'(1)) begin
              state_d = S_FRAME;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_GAP: begin
          if (i_tvalid) begin
            if (cnt_q == sh_gap_len_q - CW'(1)) begin
              state_d = S_FRAME;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Reset forces a quiet, ready interface for the cycle it is asserted.
    if (reset) begin
      i_tready = 1'b1;
      o_tvalid = 1'b0;
      o_tdata  = '0;
      o_tlast  = 1'b0;
      o_busy   = 1'b0;
    end
  end

endmodule

// File: tb/tb_periodic_cp_framer.sv
// Testbench for periodic_cp_framer: the input sample value equals its
// stream index. A reference model queues the expected {tlast, index} beats
// for each trigger, and a monitor pops and compares every output beat.
module tb_periodic_cp_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_ttrig;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_pct   = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  periodic_cp_framer dut (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_ttrig  (i_ttrig),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .o_busy   (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output backpressure, re-rolled every cycle.
  always @(posedge clk) begin
    #1;
    o_tready = ($urandom_range(99) >= 32'(bp_pct));
  end

  // Output monitor: scoreboard pop on each beat, idle bus must be zero.
  always @(negedge clk) begin
    if (o_tvalid && o_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", {31'b0, o_tlast, o_tdata}, 64'h1_ffff_ffff_ffff);
      else check("out_beat", {31'b0, o_tlast, o_tdata}, {31'b0, exp_q.pop_front()});
    end else if (!o_tvalid) begin
      check("idle_bus_zero", {31'b0, o_tlast, o_tdata}, 64'd0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference model: expected beats of one trigger burst.
  task automatic push_burst(input int fl, input int gap, input int off, input int nf, input int t);
    for (int k = 0; k < nf; k++)
      for (int j = 0; j < fl; j++)
        exp_q.push_back({(j == fl - 1), 32'(t + off + k * (fl + gap) + j)});
  endtask

  task automatic wr(input int addr, input int data);
    set_stb  = 1'b1;
    set_addr = 8'(addr);
    set_data = 32'(data);
    @(posedge clk); #1;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
  endtask

  task automatic cfg(input int fl, input int gap, input int off, input int nf);
    wr(130, fl);
    wr(131, gap);
    wr(132, off);
    wr(133, nf);
  endtask

  // Drives indices first..last, each held until accepted; trigger on ta/tb/tc.
  task automatic send_stream(input int first, input int last, input int ta, input int tb,
                             input int tc, input int vpct);
    for (int idx = first; idx <= last; idx++) begin
      bit accepted;
      int guard;
      while ($urandom_range(99) >= 32'(vpct)) begin
        i_tvalid = 1'b0;
        i_ttrig  = 1'b0;
        i_tdata  = '0;
        @(posedge clk); #1;
      end
      i_tvalid = 1'b1;
      i_tdata  = 32'(idx);
      i_ttrig  = (idx == ta) || (idx == tb) || (idx == tc);
      accepted = 1'b0;
      guard    = 0;
      while (!accepted && guard < 2000) begin
        @(negedge clk);
        accepted = i_tready;
        @(posedge clk); #1;
        guard++;
      end
      if (!accepted) begin
        check("input_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    i_tvalid = 1'b0;
    i_ttrig  = 1'b0;
    i_tdata  = '0;
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("busy_idle", {63'b0, o_busy}, 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata  = '0;
    i_ttrig  = 1'b0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    check("rst_tvalid", {63'b0, o_tvalid}, 64'd0);
    check("rst_tlast", {63'b0, o_tlast}, 64'd0);
    check("rst_busy", {63'b0, o_busy}, 64'd0);
    check("rst_tready", {63'b0, i_tready}, 64'd1);

    // 12 frames of 64, gap 16, offset 22, trigger at 100, no backpressure.
    bp_pct = 0;
    cfg(64, 16, 22, 12);
    push_burst(64, 16, 22, 12, 100);
    send_stream(0, 1064, 100, -1, -1, 100);
    check("busy_before_last", {63'b0, o_busy}, 64'd1);
    send_stream(1065, 1065, -1, -1, -1, 100);
    check("busy_after_last", {63'b0, o_busy}, 64'd0);
    send_stream(1066, 1100, -1, -1, -1, 100);
    drain();

    // Same with random stalls, plus an ignored retrigger and a later burst.
    bp_pct = 50;
    push_burst(64, 16, 22, 12, 100);
    push_burst(64, 16, 22, 12, 2000);
    send_stream(0, 2990, 100, 130, 2000, 70);
    bp_pct = 0;
    drain();

    // Back-to-back frames with no gap and no offset; junk settings ignored.
    cfg(4, 0, 0, 3);
    wr(134, 32'h0000_0007);
    wr(200, 32'h0000_0009);
    push_burst(4, 0, 0, 3, 10);
    bp_pct = 30;
    send_stream(0, 40, 10, -1, -1, 80);
    bp_pct = 0;
    drain();

    // Reset at frame 2 beat 30 abandons the burst and restores defaults.
    cfg(64, 16, 22, 12);
    push_burst(64, 16, 22, 2, 100);
    for (int j = 0; j < 30; j++) exp_q.push_back({1'b0, 32'(282 + j)});
    send_stream(0, 311, 100, -1, -1, 100);
    i_tvalid = 1'b1;
    i_tdata  = 32'd312;
    reset    = 1'b1;
    @(negedge clk);
    check("midrst_tvalid", {63'b0, o_tvalid}, 64'd0);
    check("midrst_tready", {63'b0, i_tready}, 64'd1);
    check("midrst_busy", {63'b0, o_busy}, 64'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    check("postrst_tvalid", {63'b0, o_tvalid}, 64'd0);
    check("postrst_busy", {63'b0, o_busy}, 64'd0);
    check("postrst_queue", 64'(exp_q.size()), 64'd0);
    push_burst(64, 16, 0, 1, 50);
    send_stream(0, 200, 50, -1, -1, 100);
    drain();

    // num_frames = 0 disables triggering.
    wr(133, 0);
    send_stream(0, 12, 10, -1, -1, 100);
    check("nf0_busy", {63'b0, o_busy}, 64'd0);
    send_stream(13, 50, -1, -1, -1, 100);
    drain();

    // frame_len = 0 stored as 1: single-beat frames, tlast on each.
    cfg(0, 2, 1, 3);
    push_burst(1, 2, 1, 3, 10);
    bp_pct = 40;
    send_stream(0, 40, 10, -1, -1, 100);
    bp_pct = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
